ysyx_25050148_ifu: RTL and testbench

//  Instruction fetch unit: the sender on the instruction interface that ysyx_25050148_idu consumes.
//  - Owns the architectural PC and issues one 32-bit fetch per instruction to instruction memory over a valid/ready request/response handshake.
//  - Presents {pc, instruction} to the IDU with inst_valid/inst_ready.
//  - Waits for the commit-time next PC from WBU before fetching again (multi-cycle, one instruction in flight).

---
 rtl/ysyx_25050148_ifu_pkg.sv | 22 ++
 rtl/ysyx_25050148_ifu.sv | 134 +++++++++++++
 tb/tb_ysyx_25050148_ifu.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25050148_ifu_pkg.sv
// IFU shared types: FSM state encoding, reset constants and
// the alignment helper used when accepting a committed next PC.
package ysyx_25050148_ifu_pkg;

  typedef enum logic [2:0] {
    S_REQ    = 3'd0,
    S_WAIT   = 3'd1,
    S_HOLD   = 3'd2,
    S_COMMIT = 3'd3,
    S_ERR    = 3'd4
  } ifu_state_e;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  function automatic logic pc_aligned(
    input logic [31:0] a
  );
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25050148_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word per
// instruction, hands {pc, instruction} to the IDU, waits for WBU.
//   clk, rst (async, active-low)
//   next_pc/next_pc_valid    : committed next PC from WBU
//   req_valid/ready/addr     : fetch request to instruction memory
//   rsp_valid/ready/data/err : fetch response from instruction memory
//   inst_valid/ready, pc, instruction : instruction toward IDU
//   fetch_err                : sticky fault (bus err, misaligned, timeout)
module ysyx_25050148_ifu
  import ysyx_25050148_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        next_pc_valid,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        fetch_err
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  ifu_state_e    state_q;
  logic [31:0]   pc_q;
  logic [31:0]   instr_q;
  logic          req_valid_q;
  logic          rsp_ready_q;
  logic          inst_valid_q;
  logic          fetch_err_q;
  logic [CW-1:0] cnt_q;

  // WBU commit is only observed once the IDU has taken the
  // instruction, either in the same cycle or later in S_COMMIT.
  logic commit_ev;
  logic npc_ok;

  assign commit_ev =
    (state_q == S_HOLD && inst_ready && next_pc_valid) ||
    (state_q == S_COMMIT && next_pc_valid);
  assign npc_ok = pc_aligned(next_pc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INST;
      req_valid_q  <= 1'b0;
      rsp_ready_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          req_valid_q <= 1'b1;
          if (req_valid_q && req_ready) begin
            state_q     <= S_WAIT;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          // A response on the terminal count still wins.
          if (rsp_valid && !rsp_err) begin
            state_q      <= S_HOLD;
            instr_q      <= rsp_data;
            rsp_ready_q  <= 1'b0;
            inst_valid_q <= 1'b1;
            cnt_q        <= '0;
          end else if (rsp_valid || cnt_q == CNT_LAST) begin
            state_q     <= S_ERR;
            rsp_ready_q <= 1'b0;
            fetch_err_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            state_q      <= S_COMMIT;
            inst_valid_q <= 1'b0;
          end
        end
        S_COMMIT: begin
        end
        S_ERR: begin
          req_valid_q  <= 1'b0;
          rsp_ready_q  <= 1'b0;
          inst_valid_q <= 1'b0;
          fetch_err_q  <= 1'b1;
        end
        default: begin
          state_q     <= S_ERR;
          fetch_err_q <= 1'b1;
        end
      endcase

      // Overrides the S_HOLD -> S_COMMIT step on a same-cycle commit.
      if (commit_ev) begin
        if (npc_ok) begin
          state_q     <= S_REQ;
          pc_q        <= next_pc;
          req_valid_q <= 1'b1;
        end else begin
          state_q     <= S_ERR;
          fetch_err_q <= 1'b1;
        end
      end
    end
  end

  assign req_valid   = req_valid_q;
  assign req_addr    = pc_q;
  assign rsp_ready   = rsp_ready_q;
  assign inst_valid  = inst_valid_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_ysyx_25050148_ifu.sv
// Directed + randomized bench for ysyx_25050148_ifu with a
// transaction-level PC/instruction model (TIMEOUT=8).
module tb_ysyx_25050148_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        next_pc_valid;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  logic [31:0] m_inst;

  always #5 clk = ~clk;

  ysyx_25050148_ifu #(
    .RESET_PC(RST_PC),
    .TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .next_pc      (next_pc),
    .next_pc_valid(next_pc_valid),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .pc           (pc),
    .instruction  (instruction),
    .fetch_err    (fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    next_pc       = '0;
    next_pc_valid = 1'b0;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_data      = '0;
    rsp_err       = 1'b0;
    inst_ready    = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, "_req_valid"}, req_valid, 1'b0);
    chk1({tag, "_rsp_ready"}, rsp_ready, 1'b0);
    chk1({tag, "_inst_valid"}, inst_valid, 1'b0);
    chk1({tag, "_fetch_err"}, fetch_err, 1'b0);
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_req_addr"}, req_addr, RST_PC);
    chk({tag, "_instr"}, instruction, NOP);
  endtask

  // Asserts reset now (possibly mid-cycle), checks the async
  // effect, releases on the next falling edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk_reset(tag);
    m_pc   = RST_PC;
    m_inst = NOP;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk1("req_rise", req_valid, 1'b1);
  endtask

  task automatic t_req(input int stall);
    for (int i = 0; i < stall; i++) begin
      chk1("req_hold_v", req_valid, 1'b1);
      chk("req_hold_a", req_addr, m_pc);
      req_ready     = 1'b0;
      rsp_valid     = 1'($urandom);
      rsp_err       = 1'($urandom);
      next_pc_valid = 1'($urandom);
      next_pc       = $urandom;
      @(negedge clk);
    end
    chk1("req_v", req_valid, 1'b1);
    chk("req_a", req_addr, m_pc);
    req_ready     = 1'b1;
    rsp_valid     = 1'b0;
    rsp_err       = 1'b0;
    next_pc_valid = 1'b0;
    @(negedge clk);
    req_ready = 1'b0;
    chk1("req_drop", req_valid, 1'b0);
    chk1("wait_rsp_ready", rsp_ready, 1'b1);
    chk1("wait_inst_v", inst_valid, 1'b0);
  endtask

  task automatic t_rsp(input int delay, input logic [31:0] word);
    for (int i = 0; i < delay; i++) begin
      rsp_valid     = 1'b0;
      next_pc_valid = 1'($urandom);
      next_pc       = $urandom | 32'h1;
      @(negedge clk);
      chk1("wait_rdy", rsp_ready, 1'b1);
      chk1("wait_err", fetch_err, 1'b0);
      chk("wait_pc", pc, m_pc);
    end
    next_pc_valid = 1'b0;
    rsp_valid     = 1'b1;
    rsp_err       = 1'b0;
    rsp_data      = word;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_data  = $urandom;
    m_inst    = word;
    chk1("hold_v", inst_valid, 1'b1);
    chk("hold_pc", pc, m_pc);
    chk("hold_inst", instruction, m_inst);
    chk1("hold_rsp_rdy", rsp_ready, 1'b0);
  endtask

  task automatic t_hold(input int stall, input bit same,
                        input logic [31:0] npc, input int cdelay);
    for (int i = 0; i < stall; i++) begin
      inst_ready = 1'b0;
      rsp_valid  = 1'($urandom);
      rsp_err    = 1'($urandom);
      rsp_data   = $urandom;
      @(negedge clk);
      chk1("stall_v", inst_valid, 1'b1);
      chk("stall_pc", pc, m_pc);
      chk("stall_inst", instruction, m_inst);
    end
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    inst_ready = 1'b1;
    if (same) begin
      next_pc_valid = 1'b1;
      next_pc       = npc;
    end
    @(negedge clk);
    inst_ready    = 1'b0;
    next_pc_valid = 1'b0;
    if (!same) begin
      chk1("commit_inst_v", inst_valid, 1'b0);
      chk1("commit_req_v", req_valid, 1'b0);
      for (int i = 0; i < cdelay; i++) begin
        rsp_valid = 1'($urandom);
        @(negedge clk);
        chk1("commit_wait", req_valid, 1'b0);
      end
      rsp_valid     = 1'b0;
      next_pc_valid = 1'b1;
      next_pc       = npc;
      @(negedge clk);
      next_pc_valid = 1'b0;
    end
    if (npc[1:0] == 2'b00) begin
      m_pc = npc;
      chk1("next_req_v", req_valid, 1'b1);
      chk("next_req_a", req_addr, m_pc);
      chk1("next_err", fetch_err, 1'b0);
    end else begin
      chk1("mis_err", fetch_err, 1'b1);
      chk1("mis_req_v", req_valid, 1'b0);
      chk("mis_pc", pc, m_pc);
    end
  endtask

  task automatic err_hold(input int n);
    for (int i = 0; i < n; i++) begin
      next_pc_valid = 1'($urandom);
      next_pc       = $urandom & 32'hFFFF_FFFC;
      req_ready     = 1'($urandom);
      rsp_valid     = 1'($urandom);
      inst_ready    = 1'($urandom);
      @(negedge clk);
      chk1("err_sticky", fetch_err, 1'b1);
      chk1("err_req_v", req_valid, 1'b0);
      chk1("err_inst_v", inst_valid, 1'b0);
    end
    chk("err_pc", pc, m_pc);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset("rst0");

    t_req(0);
    t_rsp(0, 32'h0000_0413);
    t_hold(3, 1'b0, 32'h8000_0010, 1);

    t_req(5);
    t_rsp(1, $urandom);
    t_hold(0, 1'b1, 32'h8000_0004, 0);

    t_req(0);
    t_rsp(7, $urandom);
    t_hold(0, 1'b0, 32'h8000_0100, 0);

    for (int k = 0; k < 24; k++) begin
      t_req(int'($urandom_range(3, 0)));
      t_rsp(int'($urandom_range(7, 0)), $urandom);
      t_hold(int'($urandom_range(3, 0)), 1'($urandom),
             $urandom & 32'hFFFF_FFFC,
             int'($urandom_range(3, 0)));
    end

    t_req(0);
    t_rsp(0, $urandom);
    t_hold(1, 1'b0, 32'h8000_0006, 1);
    err_hold(100);

    do_reset("rst_mis");
    t_req(0);
    t_rsp(0, $urandom);
    t_hold(0, 1'b1, 32'h8000_0006, 0);
    err_hold(5);

    do_reset("rst_bus");
    t_req(1);
    rsp_valid = 1'b1;
    rsp_err   = 1'b1;
    rsp_data  = $urandom;
    @(negedge clk);
    idle_inputs();
    chk1("bus_err", fetch_err, 1'b1);
    chk("bus_pc", pc, RST_PC);
    err_hold(10);

    do_reset("rst_to");
    t_req(0);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk1("to_early", fetch_err, 1'b0);
      chk1("to_rdy", rsp_ready, 1'b1);
    end
    @(negedge clk);
    chk1("to_err", fetch_err, 1'b1);
    chk1("to_rdy_off", rsp_ready, 1'b0);
    err_hold(4);

    do_reset("rst_to2");
    t_req(0);
    repeat (3) @(negedge clk);
    chk1("pre_async_rdy", rsp_ready, 1'b1);
    @(posedge clk);
    #2;
    do_reset("async");

    t_req(0);
    t_rsp(2, 32'h0010_0073);
    t_hold(0, 1'b1, 32'h8000_0020, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
